// File: rtl/i2s_tx_10xe_axi4_lite_regs.sv
// i2s_tx_10xe_axi4_lite_regs: AXI4-Lite control/status registers for the I2S TX.
// Ports: s_axi_ctrl_* AXI4-Lite slave (8-bit address, 32-bit data), core_en,
//   sclk_div, ch01_mux to the serializer; underflow_pulse in; irq level out.
// Optional: define I2S_TX_10XE_WSTRB_EN to add s_axi_ctrl_wstrb byte lanes.
module i2s_tx_10xe_axi4_lite_regs #(
    parameter logic [31:0] C_VERSION      = 32'h0001_0000,
    parameter logic [7:0]  C_SCLK_DIV_RST = 8'd4
) (
    input  logic        s_axi_ctrl_aclk,
    input  logic        s_axi_ctrl_areset,
    input  logic [7:0]  s_axi_ctrl_awaddr,
    input  logic        s_axi_ctrl_awvalid,
    output logic        s_axi_ctrl_awready,
    input  logic [31:0] s_axi_ctrl_wdata,
`ifdef I2S_TX_10XE_WSTRB_EN
    input  logic [3:0]  s_axi_ctrl_wstrb,
`endif
    input  logic        s_axi_ctrl_wvalid,
    output logic        s_axi_ctrl_wready,
    output logic [1:0]  s_axi_ctrl_bresp,
    output logic        s_axi_ctrl_bvalid,
    input  logic        s_axi_ctrl_bready,
    input  logic [7:0]  s_axi_ctrl_araddr,
    input  logic        s_axi_ctrl_arvalid,
    output logic        s_axi_ctrl_arready,
    output logic [31:0] s_axi_ctrl_rdata,
    output logic [1:0]  s_axi_ctrl_rresp,
    output logic        s_axi_ctrl_rvalid,
    input  logic        s_axi_ctrl_rready,
    output logic        core_en,
    output logic [7:0]  sclk_div,
    output logic [2:0]  ch01_mux,
    input  logic        underflow_pulse,
    output logic        irq
);

    localparam logic [7:0] A_VERSION = 8'h00;
    localparam logic [7:0] A_CTRL    = 8'h08;
    localparam logic [7:0] A_IRQ_EN  = 8'h10;
    localparam logic [7:0] A_IRQ_STS = 8'h14;
    localparam logic [7:0] A_TIMING  = 8'h20;
    localparam logic [7:0] A_CH01    = 8'h30;

    logic        clk;
    logic        rst;
    logic        aw_full;
    logic        w_full;
    logic [7:0]  aw_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be;
    logic        wr_fire;
    logic        sel_ctrl;
    logic        sel_en;
    logic        sel_sts;
    logic        sel_tim;
    logic        sel_ch;
    logic        wr_ok;
    logic        sts_clr;
    logic        en_g;
    logic        en_uf;
    logic        sts_uf;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        unused_ok;

    assign clk = s_axi_ctrl_aclk;
    assign rst = s_axi_ctrl_areset;

`ifdef I2S_TX_10XE_WSTRB_EN
    logic [3:0] wstrb_q;
    assign be = wstrb_q;
`else
    assign be = 4'hF;
`endif

    assign unused_ok = ^{wdata_q[30:8], be[2:1]};

    assign s_axi_ctrl_awready = ~aw_full;
    assign s_axi_ctrl_wready  = ~w_full;
    assign s_axi_ctrl_arready = ~s_axi_ctrl_rvalid;

    // Commit only once per latched pair; bvalid blocks re-firing.
    assign wr_fire = aw_full & w_full & ~s_axi_ctrl_bvalid;

    always_comb begin
        sel_ctrl = 1'b0;
        sel_en   = 1'b0;
        sel_sts  = 1'b0;
        sel_tim  = 1'b0;
        sel_ch   = 1'b0;
        case (aw_addr_q)
            A_CTRL:    sel_ctrl = 1'b1;
            A_IRQ_EN:  sel_en   = 1'b1;
            A_IRQ_STS: sel_sts  = 1'b1;
            A_TIMING:  sel_tim  = 1'b1;
            A_CH01:    sel_ch   = 1'b1;
            default:   ;
        endcase
    end

    assign wr_ok   = sel_ctrl | sel_en | sel_sts | sel_tim | sel_ch;
    assign sts_clr = wr_fire & sel_sts & be[0] & wdata_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full           <= 1'b0;
            w_full            <= 1'b0;
            aw_addr_q         <= '0;
            wdata_q           <= '0;
            s_axi_ctrl_bvalid <= 1'b0;
            s_axi_ctrl_bresp  <= 2'b00;
`ifdef I2S_TX_10XE_WSTRB_EN
            wstrb_q           <= '0;
`endif
        end else begin
            if (s_axi_ctrl_awvalid && !aw_full) begin
                aw_full   <= 1'b1;
                aw_addr_q <= s_axi_ctrl_awaddr;
            end
            if (s_axi_ctrl_wvalid && !w_full) begin
                w_full  <= 1'b1;
                wdata_q <= s_axi_ctrl_wdata;
`ifdef I2S_TX_10XE_WSTRB_EN
                wstrb_q <= s_axi_ctrl_wstrb;
`endif
            end
            if (wr_fire) begin
                s_axi_ctrl_bvalid <= 1'b1;
                s_axi_ctrl_bresp  <= wr_ok ? 2'b00 : 2'b10;
            end else if (s_axi_ctrl_bvalid && s_axi_ctrl_bready) begin
                s_axi_ctrl_bvalid <= 1'b0;
                aw_full           <= 1'b0;
                w_full            <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_en  <= 1'b0;
            sclk_div <= C_SCLK_DIV_RST;
            ch01_mux <= 3'd0;
            en_g     <= 1'b0;
            en_uf    <= 1'b0;
            sts_uf   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (sel_ctrl && be[0]) core_en  <= wdata_q[0];
                if (sel_tim && be[0])  sclk_div <= wdata_q[7:0];
                if (sel_ch && be[0])   ch01_mux <= wdata_q[2:0];
                if (sel_en && be[3])   en_g     <= wdata_q[31];
                if (sel_en && be[0])   en_uf    <= wdata_q[0];
            end
            // A new pulse wins over a same-cycle clear.
            sts_uf <= underflow_pulse | (sts_uf & ~sts_clr);
            irq    <= en_g & en_uf & sts_uf;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (s_axi_ctrl_araddr)
            A_VERSION: rd_data = C_VERSION;
            A_CTRL:    rd_data = {31'd0, core_en};
            A_IRQ_EN:  rd_data = {en_g, 30'd0, en_uf};
            A_IRQ_STS: rd_data = {31'd0, sts_uf};
            A_TIMING:  rd_data = {24'd0, sclk_div};
            A_CH01:    rd_data = {29'd0, ch01_mux};
            default:   rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_ctrl_rvalid <= 1'b0;
            s_axi_ctrl_rdata  <= '0;
            s_axi_ctrl_rresp  <= 2'b00;
        end else if (s_axi_ctrl_arvalid && !s_axi_ctrl_rvalid) begin
            s_axi_ctrl_rvalid <= 1'b1;
            s_axi_ctrl_rdata  <= rd_data;
            s_axi_ctrl_rresp  <= rd_err ? 2'b10 : 2'b00;
        end else if (s_axi_ctrl_rvalid && s_axi_ctrl_rready) begin
            s_axi_ctrl_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tx_10xe_axi4_lite_regs.sv
// tb_i2s_tx_10xe_axi4_lite_regs: directed bench with a register-level model.
// Core outputs are compared against the model on every falling edge.
module tb_i2s_tx_10xe_axi4_lite_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        core_en;
    logic [7:0]  sclk_div;
    logic [2:0]  ch01_mux;
    logic        upulse = 1'b0;
    logic        irq;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    i2s_tx_10xe_axi4_lite_regs dut (
        .s_axi_ctrl_aclk    (clk),
        .s_axi_ctrl_areset  (rst),
        .s_axi_ctrl_awaddr  (awaddr),
        .s_axi_ctrl_awvalid (awvalid),
        .s_axi_ctrl_awready (awready),
        .s_axi_ctrl_wdata   (wdata),
`ifdef I2S_TX_10XE_WSTRB_EN
        .s_axi_ctrl_wstrb   (wstrb),
`endif
        .s_axi_ctrl_wvalid  (wvalid),
        .s_axi_ctrl_wready  (wready),
        .s_axi_ctrl_bresp   (bresp),
        .s_axi_ctrl_bvalid  (bvalid),
        .s_axi_ctrl_bready  (bready),
        .s_axi_ctrl_araddr  (araddr),
        .s_axi_ctrl_arvalid (arvalid),
        .s_axi_ctrl_arready (arready),
        .s_axi_ctrl_rdata   (rdata),
        .s_axi_ctrl_rresp   (rresp),
        .s_axi_ctrl_rvalid  (rvalid),
        .s_axi_ctrl_rready  (rready),
        .core_en            (core_en),
        .sclk_div           (sclk_div),
        .ch01_mux           (ch01_mux),
        .underflow_pulse    (upulse),
        .irq                (irq)
    );

    // Register-level model: a write request is presented during the cycle
    // whose closing edge is the commit edge.
    logic        mreq = 1'b0;
    logic [7:0]  maddr = '0;
    logic [31:0] mdata = '0;
    logic        m_ctrl;
    logic        m_eng;
    logic        m_enu;
    logic        m_sts;
    logic [7:0]  m_tim;
    logic [2:0]  m_ch;
    logic        m_irq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctrl <= 1'b0;
            m_eng  <= 1'b0;
            m_enu  <= 1'b0;
            m_sts  <= 1'b0;
            m_tim  <= 8'd4;
            m_ch   <= 3'd0;
            m_irq  <= 1'b0;
        end else begin
            if (mreq && maddr == 8'h08) m_ctrl <= mdata[0];
            if (mreq && maddr == 8'h10) begin
                m_eng <= mdata[31];
                m_enu <= mdata[0];
            end
            if (mreq && maddr == 8'h20) m_tim <= mdata[7:0];
            if (mreq && maddr == 8'h30) m_ch <= mdata[2:0];
            if (upulse)
                m_sts <= 1'b1;
            else if (mreq && maddr == 8'h14 && mdata[0])
                m_sts <= 1'b0;
            m_irq <= m_eng && m_enu && m_sts;
        end
    end

    function automatic bit mapped(input logic [7:0] a);
        return a inside {8'h08, 8'h10, 8'h14, 8'h20, 8'h30};
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("core_en", {31'd0, core_en}, {31'd0, m_ctrl});
            chk("sclk_div", {24'd0, sclk_div}, {24'd0, m_tim});
            chk("ch01_mux", {29'd0, ch01_mux}, {29'd0, m_ch});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input int ta, input int tw, input int nbp,
                      input logic pul);
        int last;
        logic [1:0] er;
        last = (ta > tw) ? ta : tw;
        er = mapped(a) ? 2'b00 : 2'b10;
        for (int c = 0; c <= last; c++) begin
            awvalid = (c == ta);
            awaddr  = a;
            wvalid  = (c == tw);
            wdata   = d;
            @(negedge clk);
            if (c == ta) chk("awready", {31'd0, awready}, 32'd1);
            if (c == tw) chk("wready", {31'd0, wready}, 32'd1);
            if (c > ta) chk("awready_hold", {31'd0, awready}, 32'd0);
            chk("bvalid_early", {31'd0, bvalid}, 32'd0);
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        mreq    = 1'b1;
        maddr   = a;
        mdata   = d;
        upulse  = pul;
        @(negedge clk);
        chk("bvalid_pre", {31'd0, bvalid}, 32'd0);
        @(posedge clk);
        #1;
        mreq   = 1'b0;
        upulse = 1'b0;
        for (int k = 0; k < nbp; k++) begin
            awvalid = 1'b1;
            awaddr  = 8'h30;
            @(negedge clk);
            chk("bvalid_bp", {31'd0, bvalid}, 32'd1);
            chk("bresp_bp", {30'd0, bresp}, {30'd0, er});
            chk("awready_bp", {31'd0, awready}, 32'd0);
            chk("wready_bp", {31'd0, wready}, 32'd0);
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        bready  = 1'b1;
        @(negedge clk);
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, {30'd0, er});
        @(posedge clk);
        #1;
        bready = 1'b0;
        @(negedge clk);
        chk("bvalid_done", {31'd0, bvalid}, 32'd0);
        chk("awready_done", {31'd0, awready}, 32'd1);
        chk("wready_done", {31'd0, wready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] ed,
                      input logic [1:0] er, input int nbp);
        arvalid = 1'b1;
        araddr  = a;
        @(negedge clk);
        chk("arready", {31'd0, arready}, 32'd1);
        chk("rvalid_pre", {31'd0, rvalid}, 32'd0);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid", {31'd0, rvalid}, 32'd1);
        chk("rdata", rdata, ed);
        chk("rresp", {30'd0, rresp}, {30'd0, er});
        chk("arready_busy", {31'd0, arready}, 32'd0);
        for (int k = 0; k < nbp; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
            chk("rdata_hold", rdata, ed);
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        @(negedge clk);
        chk("rvalid_done", {31'd0, rvalid}, 32'd0);
        chk("arready_done", {31'd0, arready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_wready", {31'd0, wready}, 32'd1);
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_sclk", {24'd0, sclk_div}, 32'd4);

        rd(8'h00, 32'h0001_0000, 2'b00, 0);
        rd(8'h08, 32'h0000_0000, 2'b00, 0);
        rd(8'h20, 32'h0000_0004, 2'b00, 2);

        wr(8'h20, 32'hFFFF_FF3C, 0, 2, 0, 1'b0);
        chk("sclk_3c", {24'd0, sclk_div}, 32'h3C);
        rd(8'h20, 32'h0000_003C, 2'b00, 0);

        wr(8'h30, 32'hFFFF_FFFD, 2, 0, 1, 1'b0);
        rd(8'h30, 32'h0000_0005, 2'b00, 0);

        wr(8'h08, 32'h0000_0001, 0, 0, 5, 1'b0);
        chk("core_en_1", {31'd0, core_en}, 32'd1);
        chk("ch_kept", {29'd0, ch01_mux}, 32'd5);

        wr(8'h44, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
        wr(8'h00, 32'h0000_0000, 1, 0, 0, 1'b0);
        rd(8'h44, 32'h0000_0000, 2'b10, 0);
        rd(8'h00, 32'h0001_0000, 2'b00, 0);
        rd(8'h08, 32'h0000_0001, 2'b00, 0);

        wr(8'h10, 32'h8000_0001, 0, 0, 0, 1'b0);
        rd(8'h10, 32'h8000_0001, 2'b00, 0);
        upulse = 1'b1;
        @(posedge clk);
        #1;
        upulse = 1'b0;
        @(negedge clk);
        chk("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd(8'h14, 32'h0000_0001, 2'b00, 0);
        wr(8'h14, 32'h0000_0001, 0, 0, 0, 1'b1);
        rd(8'h14, 32'h0000_0001, 2'b00, 0);
        chk("irq_kept", {31'd0, irq}, 32'd1);
        wr(8'h14, 32'h0000_0001, 0, 0, 0, 1'b0);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd(8'h14, 32'h0000_0000, 2'b00, 0);

        arvalid = 1'b1;
        araddr  = 8'h20;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("mid_rvalid", {31'd0, rvalid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_rvalid", {31'd0, rvalid}, 32'd0);
        chk("ar_arready", {31'd0, arready}, 32'd1);
        chk("ar_rdata", rdata, 32'd0);
        chk("ar_core_en", {31'd0, core_en}, 32'd0);
        chk("ar_sclk", {24'd0, sclk_div}, 32'd4);
        chk("ar_ch", {29'd0, ch01_mux}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd(8'h08, 32'h0000_0000, 2'b00, 0);
        rd(8'h10, 32'h0000_0000, 2'b00, 0);
        rd(8'h20, 32'h0000_0004, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
